// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: fetch state encoding, reset/trap vector defaults and width constants
package fetch_sequencer_pkg;
    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_VEC_DEFAULT = 32'h0000_0100;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} fetch_state_e;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: imem request/response, decode handoff and redirect signals of the fetch stage
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;
    logic            halt;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_instr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            misalign_trap;
    modport master (
        input  halt, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready, redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, misalign_trap
    );
    modport slave (
        output halt, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready, redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, misalign_trap
    );
endinterface

// File: rtl/fetch_pc_next.sv
// fetch_pc_next: combinational next-pc select (redirect / trap / pc+4 / hold); MISALIGN_TRAP_EN enables the trap path
module fetch_pc_next
    import fetch_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic            advance,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_next,
    output logic            trap
);
`ifdef MISALIGN_TRAP_EN
    // misaligned redirect targets divert to the trap vector; redirects beat sequential advance
    always_comb begin
        trap = redirect_valid && (redirect_pc[1:0] != 2'b00);
        pc_next = trap ? TRAP_VEC : redirect_valid ? redirect_pc : advance ? pc + 32'd4 : pc;
    end
`else
    logic unused_bits;
    assign unused_bits = ^{TRAP_VEC, redirect_pc[1:0]};
    // targets are forced word aligned; redirects beat sequential advance
    always_comb begin
        trap = 1'b0;
        pc_next = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : advance ? pc + 32'd4 : pc;
    end
`endif
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch FSM with redirect squash; MISALIGN_TRAP_EN enables misaligned-redirect trap
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus
);
    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, if_pc_q, if_pc_d;
    logic [ILEN-1:0] if_instr_q, if_instr_d;
    logic            if_valid_q, if_valid_d, trap_q, trap_d, accept, take;

    assign accept = bus.imem_req_valid && bus.imem_req_ready;
    // a response is only kept when it arrives in WAIT with no redirect racing it
    assign take = (state_q == WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;

    fetch_pc_next #(.TRAP_VEC(TRAP_VEC)) u_pc_next (
        .pc             (pc_q),
        .advance        (take),
        .redirect_valid (bus.redirect_valid),
        .redirect_pc    (bus.redirect_pc),
        .pc_next        (pc_d),
        .trap           (trap_d)
    );

    // next state and registered decode-side outputs
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!bus.halt) state_d = REQ;
            REQ:  if (accept) state_d = bus.redirect_valid ? DROP : WAIT;
            WAIT: if (bus.imem_rsp_valid) state_d = bus.redirect_valid ? REQ : HOLD;
                  else if (bus.redirect_valid) state_d = DROP;
            HOLD: if (bus.redirect_valid) state_d = REQ;
                  else if (bus.if_ready) state_d = bus.halt ? IDLE : REQ;
            DROP: if (bus.imem_rsp_valid) state_d = bus.halt ? IDLE : REQ;
            default: state_d = IDLE;
        endcase
        if_valid_d = state_d == HOLD;
        if_pc_d = take ? pc_q : if_pc_q;
        if_instr_d = take ? bus.imem_rsp_data : if_instr_q;
    end

    // state, pc and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            trap_q     <= trap_d;
        end
    end

    assign bus.imem_req_valid = state_q == REQ;
    assign bus.imem_req_addr  = pc_q;
    assign bus.if_valid       = if_valid_q;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_instr       = if_instr_q;
    assign bus.misalign_trap  = trap_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized scoreboard bench for fetch_sequencer against a transaction-level fetch model
module tb_fetch_sequencer;
    localparam logic [31:0] RPC  = 32'h0000_8000;
    localparam logic [31:0] TVEC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    fetch_sequencer_if bus();
    fetch_sequencer #(.RESET_PC(RPC), .TRAP_VEC(TVEC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit run = 1'b0;
    int p_ready = 100, p_ifr = 100, p_redir = 0, p_halt = 0, lat_min = 0, lat_max = 0;
    bit arm = 1'b0;
    logic [31:0] arm_pc;
    bit acc;
    logic [31:0] acc_addr;
    bit pend = 1'b0;
    logic [31:0] pend_addr;
    int wait_n;
    logic [31:0] exp_pc = RPC;
    bit outst = 1'b0, o_sq = 1'b0, trap_exp = 1'b0;
    logic [31:0] o_addr;
    logic [63:0] sb[$];
    logic [63:0] e;
    int n_pres = 0, n_trap = 0;
    logic [31:0] last_pc;
    bit hold_prev = 1'b0;
    logic [31:0] prev_pc, prev_instr;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] target(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
        return (t[1:0] != 2'b00) ? TVEC : t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // transaction model: expected request address, squash tracking, scoreboard pushes
    always @(negedge clk) if (run && rst_n) begin
        chk("misalign_trap", {31'b0, bus.misalign_trap}, {31'b0, trap_exp});
        if (bus.misalign_trap) n_trap++;
        trap_exp = 1'b0;
        if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_pc);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            chk("one_outstanding", {31'b0, outst}, 32'd0);
            outst = 1'b1; o_sq = 1'b0; o_addr = exp_pc;
        end else if (bus.imem_rsp_valid) begin
            if (!o_sq && !bus.redirect_valid) begin
                sb.push_back({o_addr, mem(o_addr)});
                exp_pc = o_addr + 32'd4;
            end
            outst = 1'b0;
        end
        if (bus.redirect_valid) begin
            o_sq = 1'b1;
            exp_pc = target(bus.redirect_pc);
`ifdef MISALIGN_TRAP_EN
            trap_exp = bus.redirect_pc[1:0] != 2'b00;
`endif
        end
    end

    // monitor: compares presented instructions against the scoreboard, checks HOLD stability
    always @(negedge clk) if (run && rst_n) begin
        if (bus.if_valid) chk("no_req_in_hold", {31'b0, bus.imem_req_valid}, 32'd0);
        if (hold_prev) begin
            chk("hold_valid", {31'b0, bus.if_valid}, 32'd1);
            chk("hold_pc", bus.if_pc, prev_pc);
            chk("hold_instr", bus.if_instr, prev_instr);
        end
        if (bus.if_valid && bus.if_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL present: unexpected instruction at pc %h", bus.if_pc);
            end else begin
                e = sb.pop_front();
                chk("if_pc", bus.if_pc, e[63:32]);
                chk("if_instr", bus.if_instr, e[31:0]);
                n_pres++;
                last_pc = bus.if_pc;
            end
        end else if (bus.if_valid && bus.redirect_valid && sb.size() != 0) begin
            void'(sb.pop_front());
        end
        hold_prev = bus.if_valid && !bus.if_ready && !bus.redirect_valid;
        prev_pc = bus.if_pc;
        prev_instr = bus.if_instr;
    end

    // one cycle of stimulus: memory responder plus randomized handshakes and redirects
    task automatic step();
        acc = 1'b0;
        @(negedge clk);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            acc = 1'b1; acc_addr = bus.imem_req_addr;
            pend = 1'b1; pend_addr = bus.imem_req_addr;
            wait_n = $urandom_range(lat_max, lat_min);
        end
        @(posedge clk);
        #1;
        bus.imem_rsp_valid = 1'b0;
        if (pend) begin
            if (wait_n == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data = mem(pend_addr);
                pend = 1'b0;
            end else wait_n--;
        end
        bus.imem_req_ready = ($urandom_range(0, 99) < p_ready);
        bus.if_ready = ($urandom_range(0, 99) < p_ifr);
        bus.halt = ($urandom_range(0, 99) < p_halt);
        bus.redirect_valid = 1'b0;
        if (arm && acc) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc = arm_pc;
            arm = 1'b0;
        end else if ($urandom_range(0, 99) < p_redir) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc = $urandom_range(0, 32'h3FFF);
            if ($urandom_range(0, 3) != 0) bus.redirect_pc[1:0] = 2'b00;
        end
    endtask

    task automatic wait_acc(input string name);
        int n = 0;
        do begin step(); n++; end while (!acc && n < 100);
        if (!acc) begin checks++; errors++; $display("FAIL %s: no request accepted within 100 cycles", name); end
    endtask

    task automatic expect_req(input string name, input logic [31:0] a);
        wait_acc(name);
        if (acc) chk(name, acc_addr, a);
    endtask

    task automatic expect_present(input string name, input logic [31:0] pc);
        int n0 = n_pres;
        int n = 0;
        while (n_pres == n0 && n < 100) begin step(); n++; end
        if (n_pres == n0) begin checks++; errors++; $display("FAIL %s: nothing presented within 100 cycles", name); end
        else chk(name, last_pc, pc);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'b0, bus.imem_req_valid}, 32'd0);
        chk({tag, "_if_valid"}, {31'b0, bus.if_valid}, 32'd0);
        chk({tag, "_if_pc"}, bus.if_pc, 32'd0);
        chk({tag, "_if_instr"}, bus.if_instr, 32'd0);
        chk({tag, "_trap"}, {31'b0, bus.misalign_trap}, 32'd0);
    endtask

    initial begin
        int n0, t0;
        bus.halt = 1'b0; bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
        bus.if_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        #2 rst_n = 1'b0;
        #10 check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1; run = 1'b1;
        @(negedge clk); chk("first_cycle_idle", {31'b0, bus.imem_req_valid}, 32'd0);
        @(negedge clk); chk("first_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        chk("first_req_addr", bus.imem_req_addr, RPC);
        expect_req("seq0", 32'h0000_8000);
        expect_req("seq1", 32'h0000_8004);
        expect_req("seq2", 32'h0000_8008);
        n0 = n_pres;
        repeat (15) step();
        chk("throughput", 32'(n_pres - n0), 32'd5);
        p_ifr = 0;
        repeat (8) step();
        p_ifr = 100;
        lat_min = 1; lat_max = 1; arm = 1'b1; arm_pc = 32'h0000_9000;
        wait_acc("arm_wait");
        expect_req("redir_wait_addr", 32'h0000_9000);
        expect_present("redir_wait_pc", 32'h0000_9000);
        lat_min = 0; lat_max = 0; arm = 1'b1; arm_pc = 32'h0000_5000;
        wait_acc("arm_rsp");
        expect_req("redir_rsp_addr", 32'h0000_5000);
        expect_present("redir_rsp_pc", 32'h0000_5000);
        arm = 1'b1; arm_pc = 32'hFFFF_FFFC;
        wait_acc("arm_wrap");
        expect_req("wrap_top", 32'hFFFF_FFFC);
        expect_req("wrap_zero", 32'h0000_0000);
        t0 = n_trap;
        arm = 1'b1; arm_pc = 32'h0000_2002;
        wait_acc("arm_mis");
`ifdef MISALIGN_TRAP_EN
        expect_req("misalign_addr", TVEC);
        chk("trap_count", 32'(n_trap - t0), 32'd1);
`else
        expect_req("misalign_addr", 32'h0000_2000);
        chk("trap_count", 32'(n_trap - t0), 32'd0);
`endif
        p_ready = 70; p_ifr = 70; p_redir = 8; p_halt = 10; lat_min = 0; lat_max = 3;
        repeat (3000) step();
        p_ready = 100; p_ifr = 100; p_redir = 0; p_halt = 0;
        repeat (30) step();
        chk("sb_drained", sb.size(), 32'd0);
        if (n_pres < 200) begin checks++; errors++; $display("FAIL progress: %0d instructions presented, need 200", n_pres); end
        else checks++;
        lat_min = 2; lat_max = 2;
        wait_acc("pre_reset");
        run = 1'b0;
        rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        pend = 1'b0; bus.imem_rsp_valid = 1'b0; bus.redirect_valid = 1'b0;
        exp_pc = RPC; outst = 1'b0; o_sq = 1'b0; trap_exp = 1'b0; hold_prev = 1'b0; sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; run = 1'b1;
        expect_req("post_reset_addr", RPC);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the single-issue RISC-V core. It owns the architectural PC register and issues one 32-bit instruction-memory read at a time over a valid/ready request channel. It presents each returned instruction with its PC to decode over a valid/ready channel. It accepts PC redirects from the next-PC selection logic (branch/JAL/JALR outcome) and squashes any fetch that is stale.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- TRAP_VEC, 32'h0000_0100, misaligned-target vector; only used when MISALIGN_TRAP_EN is defined.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- halt  in  1  stop launching new fetches; an outstanding fetch completes
- imem_req_valid  out  1  read request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word address of request (= PC)
- imem_rsp_valid  in  1  read data valid; exactly one response per accepted request, at least 1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode consumes
- if_pc  out  32  PC of presented instruction
- if_instr  out  32  presented instruction
- redirect_valid  in  1  one-cycle redirect strobe from next-PC logic
- redirect_pc  in  32  redirect target
- misalign_trap  out  1  one-cycle pulse, misaligned redirect taken

## Operation
- States: IDLE, REQ, WAIT, HOLD, DROP. All outputs are registered except imem_req_valid and imem_req_addr, which are decoded from state and pc.
- Reset: state=IDLE, pc=RESET_PC, if_pc=0, if_instr=0, if_valid=0, imem_req_valid=0, misalign_trap=0.
- IDLE: !halt -> REQ. No request.
- REQ: imem_req_valid=1, imem_req_addr=pc. On handshake -> WAIT.
- WAIT: on imem_rsp_valid -> latch if_instr=rsp_data, if_pc=pc, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), -> HOLD.
- HOLD: if_valid=1. On if_ready -> REQ, or IDLE if halt.
- DROP: discard the next imem_rsp_valid, then -> REQ, or IDLE if halt.
- Redirect: pc<=redirect_pc in every state. It has priority over pc+4.
  - REQ, no handshake this cycle: stay in REQ with the new address. This is the only permitted address change under valid&&!ready; the imem wrapper is specified to allow it.
  - REQ with handshake same cycle, or WAIT with no response: -> DROP.
  - WAIT with response same cycle: discard the response and -> REQ.
  - HOLD: -> REQ and if_valid clears next cycle. A same-cycle if_ready transfer is also flushed by decode via the same strobe.
  - DROP: stay in DROP.
  - IDLE: pc updated, no fetch while halt.
- At most one request outstanding; there is never a second request before its response.

## Timing
- Fetch latency: REQ accepted at cycle n, response at n+1 -> if_valid at n+2. Best throughput is one instruction per 3 cycles with if_ready=1.
- Redirect at cycle n -> new address on imem_req_addr no later than n+1, or after the stale response in DROP.
- Reset deassertion: first request at cycle 2 after rst_n rises (IDLE -> REQ).
- rst_n asserted mid-transaction returns everything to reset values immediately. Memory must also be reset, so no response is expected afterwards.

## Configuration
- MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0]!=0 loads pc<=TRAP_VEC instead, and misalign_trap=1 for the next cycle. All state transitions are otherwise identical.
- Undefined: redirect_pc[1:0] is forced to 2'b00. misalign_trap is tied 0 and TRAP_VEC is unused.

## Structure
- Shared core package/defines: fetch state encoding, RESET_PC/TRAP_VEC defaults, instruction-width constant, with the existing ALU code defines.
- One sub-module: fetch_pc_next, a combinational next-pc select (redirect / trap / pc+4 / hold). The FSM and output registers stay in fetch_sequencer.

## Test plan
- Reset with RESET_PC=32'h0000_8000, ready=1, 1-cycle memory -> requests at 8000, 8004, 8008; if_valid every 3rd cycle with matching if_pc.
- if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc and if_instr stay stable, and no new request is issued.
- Redirect to 32'h0000_9000 in WAIT with response 1 cycle later -> response dropped, next request addr 9000, if_pc 9000 presented.
- Redirect in the same cycle as imem_rsp_valid -> that response is never presented, and the next request uses the redirect target.
- PC 32'hFFFF_FFFC fetched -> next request addr 32'h0000_0000.
- With MISALIGN_TRAP_EN, redirect_pc=32'h0000_2002 -> misalign_trap pulses once, and the next request addr is TRAP_VEC (32'h0000_0100). Without the macro, the next request addr is 32'h0000_2000.
